// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared state encoding and default timing constants for the button conditioner.
package btn_cond_pkg;

    typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} btn_state_t;

    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int REPEAT_DEFAULT = 16;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input, reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner: debounces a raw button into a level and a one-cycle advance pulse.
// Define BTN_AUTOREPEAT_EN to add periodic repeat pulses while the button is held.
module btn_pulse_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic enable,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic pulse_q, pulse_d;
    logic level_q, level_d;
    logic btn_sync;
    logic press;

    sync2 u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(btn_raw),
        .q_o(btn_sync)
    );

    // The counter restarts from zero on every state entry, so it only ever counts one run.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        press = 1'b0;
        case (state_q)
            LOW: begin
                if (btn_sync) begin
                    state_d = RISE_CHK;
                    cnt_d = '0;
                end
            end
            RISE_CHK: begin
                if (!btn_sync) begin
                    state_d = LOW;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d = '0;
                    press = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!btn_sync) begin
                    state_d = FALL_CHK;
                    cnt_d = '0;
                end
            end
            FALL_CHK: begin
                if (btn_sync) begin
                    state_d = HIGH;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d = '0;
            end
        endcase
        level_d = (state_d == HIGH) || (state_d == FALL_CHK);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic rep_hit;

    // Counts every cycle spent in HIGH, holds elsewhere, restarts on each entry to HIGH.
    always_comb begin
        rep_hit = (state_q == HIGH) && (rep_q == REP_LAST);
        rep_d = rep_q;
        if (state_q == HIGH)
            rep_d = rep_hit ? '0 : rep_q + 1'b1;
        if (state_d == HIGH && state_q != HIGH)
            rep_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rep_q <= '0;
        else
            rep_q <= rep_d;
    end

    assign pulse_d = (press | rep_hit) & enable;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
    assign pulse_d = press & enable;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: doc/btn_pulse_conditioner.md
# btn_pulse_conditioner

Conditions a raw, asynchronous, bouncing push-button into a clean debounced level and a single-cycle advance pulse. It sits directly upstream of the seven-state step FSM and drives that FSM's `x` input, so one physical press advances it by exactly one state. Synchronizer, debounce FSM and pulse generation are all clocked by the FSM's clock.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a level change; legal range ≥ 1.
- `REPEAT_CYCLES`, default 16: auto-repeat period in cycles while held; used only when auto-repeat is compiled in; legal range ≥ 2.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `btn_raw`  in  1: asynchronous raw button, active-high.
- `enable`  in  1: when 0, `pulse` is suppressed; debouncing continues.
- `pulse`  out  1: one-cycle advance strobe, registered; connects to step FSM `x`.
- `level`  out  1: debounced button level, registered.

## Operation
- **Synchronizer:** two flops `s1` then `s2`. `btn_sync = s2`. Both flops reset to 0.
- **Debounce FSM**, 4 states, reset state `LOW`:
  - `LOW` (level 0): if `btn_sync=1`, go to `RISE_CHK` and set cnt=0.
  - `RISE_CHK` (level 0): on `btn_sync=1`, increment cnt. When cnt==DEBOUNCE_CYCLES-1 and `btn_sync=1`, go to `HIGH` (commit press). On `btn_sync=0`, go to `LOW` and set cnt=0.
  - `HIGH` (level 1): if `btn_sync=0`, go to `FALL_CHK` and set cnt=0.
  - `FALL_CHK` (level 1): on `btn_sync=0`, increment cnt. When cnt==DEBOUNCE_CYCLES-1 and `btn_sync=0`, go to `LOW` (commit release). On `btn_sync=1`, go to `HIGH` and set cnt=0.
- **Counter:** cnt width is $clog2(DEBOUNCE_CYCLES+1), unsigned. It never wraps and is cleared on every state entry.
- **Pulse:** `pulse` is registered and equals (press commit) AND `enable`. It is high for exactly one cycle. A release commit never pulses.
- **Level:** `level` is registered and is 1 in `HIGH` and `FALL_CHK`.
- **Illegal state encoding:** next state is `LOW`.
- **Reset values:** `pulse`=0, `level`=0, state `LOW`, cnt 0, repeat counter 0, sync flops 0.
- **Reset mid-operation:** all press progress is discarded. If the button is still held after `rst` falls, it is treated as a new press and pulses after the normal latency.

## Timing
- `btn_raw` rises before edge k and then stays stable: `s2`=1 after edge k+1, `RISE_CHK` is entered at edge k+2, and the commit happens at edge k+2+DEBOUNCE_CYCLES. `pulse` and `level` are high in the cycle after that edge.
- Press latency is DEBOUNCE_CYCLES+2 cycles; release latency on `level` is the same.
- Any bounce shorter than DEBOUNCE_CYCLES synchronized samples produces no change on `level` and no `pulse`.
- `enable` is sampled in the commit cycle only. A press committed while `enable`=0 is consumed: no deferred pulse.
- Minimum spacing between pulses, without repeat, is 2·(DEBOUNCE_CYCLES+1) cycles.

## Configuration
- Macro `BTN_AUTOREPEAT_EN`.
- **Defined:**
  - A repeat counter runs only in `HIGH`. It clears on entry to `HIGH`, on return from `FALL_CHK`, and on every repeat pulse.
  - When it reaches REPEAT_CYCLES-1, `pulse` = `enable` for one cycle. Repeat pulses therefore occur every REPEAT_CYCLES cycles after the press pulse while held.
  - `FALL_CHK` freezes the repeat counter.
- **Undefined:** no repeat counter is instantiated and there is exactly one pulse per accepted press. `REPEAT_CYCLES` is ignored.

## Structure
- Package `btn_cond_pkg`:
  - `btn_state_t` enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK}.
  - Default constants `DEBOUNCE_DEFAULT`=4 and `REPEAT_DEFAULT`=16.
- Sub-module `sync2`: parameterless two-flop synchronizer with synchronous active-high reset to 0. It is reused for other async inputs.

## Test plan
- **Clean press:** D=4, `enable`=1, `btn_raw` 0→1 held 20 cycles → `pulse` high exactly 1 cycle, 6 cycles after first sampling edge. `level`=1 in the same cycle.
- **Bounce:** `btn_raw` 1,0,1,0 (one cycle each), then 0 → `pulse` and `level` stay 0 throughout.
- **Hold and release glitch:** hold 40 cycles with a 2-cycle low glitch mid-hold → one `pulse` total. `level` stays 1 until final release plus 6 cycles.
- **Enable gating:** press with `enable`=0, then `enable`=1 while still held → no pulse. `level` still goes to 1.
- **Reset mid-press:** `rst` asserted 1 cycle while in `RISE_CHK`, button still held → `pulse`/`level` 0 at reset. Exactly one pulse 6 cycles after `rst` deasserts.
- **Auto-repeat:** with `BTN_AUTOREPEAT_EN` and REPEAT_CYCLES=16, hold 60 cycles → pulses at press commit and at +16, +32, +48 cycles. Without the macro → a single pulse.
